// File: rtl/siphash_msg_padder.sv
// Byte-serial message padder for a SipHash core: packs bytes little-endian into
// 64-bit words, appends the length byte and sequences init/compress/finalize.
module siphash_msg_padder (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        long_mode,
  input  logic        msg_empty,
  input  logic [7:0]  data_in,
  input  logic        data_valid,
  input  logic        data_last,
  output logic        data_ready,
  input  logic        core_ready,
  output logic        initalize,
  output logic        compress,
  output logic        finalize,
  output logic        long,
  output logic [63:0] mi,
  output logic        busy,
  output logic        done
);

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    INIT    = 4'd1,
    COLLECT = 4'd2,
    COMP    = 4'd3,
    GUARD   = 4'd4,
    WAITC   = 4'd5,
    FIN     = 4'd6,
    GUARDF  = 4'd7,
    WAITF   = 4'd8
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [2:0]  pos;
  logic [7:0]  length;
  logic        len_pending;
  logic        final_pending;
  logic        empty_lat;
  logic        accept;

  assign accept = (state == COLLECT) && data_valid;

  // Next-state decode; all registered outputs are derived from it.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) state_nxt = INIT;
        else       state_nxt = IDLE;
      end
      INIT: begin
        // An empty message reuses the length-word path to emit its single zero word.
        if (empty_lat) state_nxt = GUARD;
        else           state_nxt = COLLECT;
      end
      COLLECT: begin
        if (accept && ((pos == 3'd7) || data_last)) state_nxt = COMP;
        else                                        state_nxt = COLLECT;
      end
      COMP: begin
        if (core_ready) state_nxt = GUARD;
        else            state_nxt = COMP;
      end
      GUARD: state_nxt = WAITC;
      WAITC: begin
        if (!core_ready)        state_nxt = WAITC;
        else if (len_pending)   state_nxt = COMP;
        else if (final_pending) state_nxt = FIN;
        else                    state_nxt = COLLECT;
      end
      FIN:    state_nxt = GUARDF;
      GUARDF: state_nxt = WAITF;
      WAITF: begin
        if (core_ready) state_nxt = IDLE;
        else            state_nxt = WAITF;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, registered control outputs and the message word datapath.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      data_ready    <= 1'b0;
      initalize     <= 1'b0;
      compress      <= 1'b0;
      finalize      <= 1'b0;
      long          <= 1'b0;
      mi            <= 64'h0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pos           <= 3'd0;
      length        <= 8'd0;
      len_pending   <= 1'b0;
      final_pending <= 1'b0;
      empty_lat     <= 1'b0;
    end else begin
      state      <= state_nxt;
      data_ready <= (state_nxt == COLLECT);
      busy       <= (state_nxt != IDLE);
      initalize  <= (state_nxt == INIT);
      finalize   <= (state_nxt == FIN);
      // compress lands in the GUARD cycle, while mi still holds the word.
      compress   <= (state == COMP) && core_ready;
      done       <= (state == WAITF) && core_ready;

      case (state)
        IDLE: begin
          if (start) begin
            long          <= long_mode;
            empty_lat     <= msg_empty;
            pos           <= 3'd0;
            length        <= 8'd0;
            mi            <= 64'h0;
            len_pending   <= msg_empty;
            final_pending <= 1'b0;
          end else begin
            long <= long;
          end
        end
        COLLECT: begin
          if (accept) begin
            mi[{pos, 3'b000} +: 8] <= data_in;
            pos                    <= pos + 3'd1;
            length                 <= length + 8'd1;
            if (data_last) begin
              if (pos == 3'd7) begin
                len_pending <= 1'b1;
              end else begin
                mi[63:56]     <= length + 8'd1;
                final_pending <= 1'b1;
              end
            end else begin
              len_pending <= len_pending;
            end
          end else begin
            pos <= pos;
          end
        end
        WAITC: begin
          if (core_ready) begin
            if (len_pending) begin
              mi            <= {length, 56'h0};
              len_pending   <= 1'b0;
              final_pending <= 1'b1;
            end else if (final_pending) begin
              final_pending <= 1'b0;
            end else begin
              mi  <= 64'h0;
              pos <= 3'd0;
            end
          end else begin
            pos <= pos;
          end
        end
        default: begin
          pos <= pos;
        end
      endcase
    end
  end

endmodule

// File: doc/siphash_msg_padder.md
SIPHASH_MSG_PADDER -- requirements
Module: siphash_msg_padder

Interface
REQ-001 SHALL have no parameters; all widths are fixed as listed.
REQ-002 SHALL use one clock; reset is synchronous and active-high.
REQ-003 clk  in  1  sole clock; all state changes on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 start  in  1  begin a new message; sampled only in IDLE.
REQ-006 long_mode  in  1  128-bit tag select; sampled with start.
REQ-007 msg_empty  in  1  zero-length message flag; sampled with start.
REQ-008 data_in  in  8  message byte.
REQ-009 data_valid  in  1  data_in is valid.
REQ-010 data_last  in  1  final message byte; qualified by data_valid.
REQ-011 data_ready  out  1  padder accepts a byte this cycle.
REQ-012 core_ready  in  1  ready from the downstream SipHash core.
REQ-013 initalize  out  1  one-cycle init pulse to the core.
REQ-014 compress  out  1  one-cycle compress pulse to the core.
REQ-015 finalize  out  1  one-cycle finalize pulse to the core.
REQ-016 long  out  1  registered long_mode, held until the next start.
REQ-017 mi  out  64  message word to the core; stable from the compress cycle until the next word is built.
REQ-018 busy  out  1  high in every state except IDLE.
REQ-019 done  out  1  one-cycle pulse when the core returns ready after finalize.

Function
REQ-020 States SHALL be IDLE, INIT, COLLECT, COMP, GUARD, WAITC, FIN, GUARDF, WAITF.
REQ-021 IDLE: on start=1, latch long_mode and msg_empty, clear the byte position (3b), the length counter (8b) and mi, then go to INIT.
REQ-022 IDLE: start=0 holds IDLE; start in any other state SHALL be ignored.
REQ-023 INIT: assert initalize for exactly 1 cycle; go to GUARD if msg_empty, else COLLECT.
REQ-024 msg_empty path: issue one compress with mi=64'h0 (length 0, no bytes).
REQ-025 COLLECT: data_ready=1; data_ready SHALL be 0 in every other state.
REQ-026 A byte is accepted when data_valid=1 and data_ready=1.
REQ-027 Each accepted byte SHALL be written to mi[8*pos+7:8*pos] (little-endian); pos and length increment, and length wraps modulo 256.
REQ-028 Accept at pos=7 without last: go to COMP.
REQ-029 Accept at pos<7 with last: set mi[63:56]=length including this byte mod 256, leave the unused bytes 0, set final_pending, go to COMP.
REQ-030 Accept at pos=7 with last: go to COMP, set len_pending; the next word SHALL be {length[7:0],56'h0}, followed by final_pending.
REQ-031 COMP: wait for core_ready=1, then assert compress for 1 cycle with mi valid, go to GUARD.
REQ-032 GUARD: one cycle in which core_ready is ignored (the core's ready drops one cycle late); go to WAITC.
REQ-033 WAITC: on core_ready=1, take the first matching exit:
  - len_pending: load the length word, clear len_pending, go to COMP.
  - final_pending: go to FIN.
  - otherwise: clear mi and pos, go to COLLECT.
REQ-034 FIN: assert finalize for 1 cycle, go to GUARDF.
REQ-035 GUARDF: one cycle, then WAITF.
REQ-036 WAITF: on core_ready=1, pulse done and go to IDLE; the padder SHALL NOT count rounds.
REQ-037 At most one of initalize, compress and finalize SHALL be high in any cycle.
REQ-038 Each such pulse SHALL be high for exactly one cycle.
REQ-039 data_valid while data_ready=0 SHALL be ignored, with no state change.

Reset
REQ-040 reset=1 SHALL force IDLE from any state, including mid-message.
REQ-041 Reset SHALL clear all outputs to 0: data_ready, initalize, compress, finalize, long, mi, busy, done.
REQ-042 Reset SHALL clear pos, length, len_pending, final_pending and the latched msg_empty.
REQ-043 The first start after reset SHALL behave identically to a start after power-up.

Verification
REQ-044 Bytes 00..06, last on 06, core_ready=1 -> one compress with mi=64'h0706050403020100, then one finalize, then done.
REQ-045 Bytes 00..0E (15 bytes) -> compress mi=64'h0706050403020100, then compress mi=64'h0F0E0D0C0B0A0908, then finalize.
REQ-046 Bytes 00..07, last on 07 -> compress 64'h0706050403020100, then compress 64'h0800000000000000; msg_empty=1 -> one compress of 64'h0, then finalize.
REQ-047 256 bytes of 0xAA -> 32 full-word compresses, then compress 64'h0000000000000000 (length wrap), then finalize; long_mode=1 -> long=1 throughout.
REQ-048 core_ready held 0 for 20 cycles after a compress -> no further pulse, data_ready=0, mi stable; resumes within 2 cycles of core_ready=1.
REQ-049 reset=1 after byte 3 of a message -> all outputs 0 the next cycle; a new 7-byte message then produces the REQ-044 result.
